// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: shares one SPI SRAM between instruction fetch and data
// load/store ports. Round-robin arbitration, one SPI mode-0 transaction per
// grant: 8-bit command, ADDR_BITS address, then 1/2/4 data bytes.
// Optional macro SPI_RAM_SEQ_FETCH_EN keeps the read stream open after an
// instruction fetch so a sequential fetch skips the command/address phases.
module spi_ram_arbiter #(
    parameter int         ADDR_BITS = 24,
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 instr_req,
    input  logic [ADDR_BITS-1:0] instr_addr,
    output logic [31:0]          instr_rdata,
    output logic                 instr_ready,
    input  logic                 data_req,
    input  logic                 data_we,
    input  logic [1:0]           data_len,
    input  logic [ADDR_BITS-1:0] data_addr,
    input  logic [31:0]          data_wdata,
    output logic [31:0]          data_rdata,
    output logic                 data_ready,
    output logic                 spi_select,
    output logic                 spi_clk,
    output logic                 spi_mosi,
    input  logic                 spi_miso,
    output logic                 busy
);

    localparam int TXW = 8 + ADDR_BITS + 32;
    localparam int CW  = $clog2(ADDR_BITS + 33);

    typedef enum logic [2:0] {S_IDLE, S_CLOSE, S_CMD, S_ADDR, S_DATA, S_DONE} state_t;

    state_t          state, state_nxt;
    logic            phase;          // 0 = SPI clock low half, 1 = high half
    logic [CW-1:0]   cnt;            // bit index within the current phase
    logic [TXW-1:0]  tx;             // outgoing bits, MSB is on the wire
    logic [31:0]     rx, rx_nxt;
    logic            cur_instr, cur_we, last_instr;
    logic [1:0]      cur_len;
    logic [CW-1:0]   data_last;
    logic [31:0]     wbytes;
    logic            any_req, grant_instr, seq_hit, stream_open, keep_open;

    assign any_req     = instr_req | data_req;
    // On a tie the port not served last wins
    assign grant_instr = instr_req & (~data_req | ~last_instr);
    // Byte 0 goes out first, so reorder the write word byte-wise
    assign wbytes      = (grant_instr | ~data_we) ? 32'h0 :
                         {data_wdata[7:0], data_wdata[15:8], data_wdata[23:16], data_wdata[31:24]};

`ifdef SPI_RAM_SEQ_FETCH_EN
    logic [ADDR_BITS-1:0] next_addr;
    assign seq_hit   = stream_open & grant_instr & (instr_addr == next_addr);
    assign keep_open = cur_instr;

    // Track the open read stream and the address it will deliver next
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stream_open <= 1'b0;
            next_addr   <= '0;
        end else begin
            if (state == S_IDLE && any_req && grant_instr)
                next_addr <= instr_addr + ADDR_BITS'(4);
            if (state == S_DONE)
                stream_open <= cur_instr;
            else if (state == S_CLOSE)
                stream_open <= 1'b0;
        end
    end
`else
    assign seq_hit     = 1'b0;
    assign keep_open   = 1'b0;
    assign stream_open = 1'b0;
`endif

    // Number of DATA bits minus one for the latched length
    always_comb begin
        case (cur_len)
            2'b00:   data_last = CW'(7);
            2'b01:   data_last = CW'(15);
            default: data_last = CW'(31);
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: phases advance on the edge ending the high half of their last bit
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req) state_nxt = seq_hit ? S_DATA : (stream_open ? S_CLOSE : S_CMD);
            S_CLOSE: state_nxt = S_CMD;
            S_CMD:   if (phase && cnt == CW'(7)) state_nxt = S_ADDR;
            S_ADDR:  if (phase && cnt == CW'(ADDR_BITS - 1)) state_nxt = S_DATA;
            S_DATA:  if (phase && cnt == data_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Received bit k of the data phase lands in byte k/8, MSB first
    always_comb begin
        rx_nxt = rx;
        if (state == S_DATA && phase)
            rx_nxt[{cnt[4:3], ~cnt[2:0]}] = spi_miso;
    end

    // Datapath: latch the granted request, then shift one bit per two clocks
    always_ff @(posedge clk) begin
        if (!rstn) begin
            phase       <= 1'b0;
            cnt         <= '0;
            tx          <= '0;
            rx          <= '0;
            cur_instr   <= 1'b0;
            cur_we      <= 1'b0;
            cur_len     <= 2'b00;
            last_instr  <= 1'b1;
            instr_rdata <= '0;
            data_rdata  <= '0;
        end else if (state == S_IDLE) begin
            if (any_req) begin
                cur_instr  <= grant_instr;
                last_instr <= grant_instr;
                cur_we     <= ~grant_instr & data_we;
                cur_len    <= grant_instr ? 2'b10 : data_len;
                tx         <= seq_hit ? '0 :
                              {(grant_instr | ~data_we) ? CMD_READ : CMD_WRITE,
                               grant_instr ? instr_addr : data_addr, wbytes};
                rx         <= '0;
                phase      <= 1'b0;
                cnt        <= '0;
            end
        end else if (state == S_CMD || state == S_ADDR || state == S_DATA) begin
            phase <= ~phase;
            if (phase) begin
                tx  <= {tx[TXW-2:0], 1'b0};
                rx  <= rx_nxt;
                cnt <= (state_nxt != state) ? '0 : cnt + CW'(1);
            end
            if (state_nxt == S_DONE) begin
                tx <= '0;
                if (cur_instr)    instr_rdata <= rx_nxt;
                else if (!cur_we) data_rdata  <= rx_nxt;
            end
        end
    end

    // Chip select: low while shifting, and while a fetch stream is held open
    always_comb begin
        case (state)
            S_IDLE:                 spi_select = ~stream_open;
            S_CMD, S_ADDR, S_DATA:  spi_select = 1'b0;
            S_DONE:                 spi_select = ~keep_open;
            default:                spi_select = 1'b1;
        endcase
    end

    assign spi_clk     = phase;
    assign spi_mosi    = tx[TXW-1] & (state != S_CLOSE);
    assign instr_ready = (state == S_DONE) &  cur_instr;
    assign data_ready  = (state == S_DONE) & ~cur_instr;
    assign busy        = (state != S_IDLE);

endmodule
